// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ifid_rn;
  logic [REG_W-1:0] ifid_rm;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_br_taken;
  logic             exmem_memreq;
  logic             dmem_ready;

  logic             pc_we;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             mem_tmo_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output ifid_rn, ifid_rm, idex_memread, idex_rd,
           exmem_br_taken, exmem_memreq, dmem_ready,
    input  pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_tmo_err, stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  ifid_rn, ifid_rm, idex_memread, idex_rd,
           exmem_br_taken, exmem_memreq, dmem_ready,
    output pc_we, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_tmo_err, stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline; define PIPE_HZD_PERF_EN for the
// saturating performance counters.
//   state    | meaning
//   RUN      | normal flow, all hazards evaluated (memwait > branch > load-use)
//   LU_STALL | bubble in ID/EX after a load-use stall; load-use not re-checked
//   MEM_WAIT | pipeline frozen on a data-memory access, timeout counter running
//   REDIRECT | bubbles after a taken branch; only memwait is honoured
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int MEM_TMO  = 15,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int TMO_W = $clog2(MEM_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TMO);
  localparam logic [REG_W-1:0] XZR     = REG_W'(ZERO_REG);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmoNext;
  logic             tmoErr;
  logic             errSet;

  logic memWait;
  logic luHaz;
  logic tmoHit;
  logic allowMem;
  logic allowBr;
  logic allowLu;

  logic pcWe;
  logic ifidEn;
  logic idexEn;
  logic exmemEn;
  logic memwbEn;
  logic ifidFlush;
  logic idexFlush;
  logic exmemFlush;
  logic memwbFlush;

  assign memWait = hz.exmem_memreq & ~hz.dmem_ready;
  assign luHaz   = hz.idex_memread & (hz.idex_rd != XZR) &
                   ((hz.idex_rd == hz.ifid_rn) | (hz.idex_rd == hz.ifid_rm));
  assign tmoHit  = (tmo == TMO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      tmo    <= '0;
      tmoErr <= 1'b0;
    end else begin
      state <= stateNext;
      tmo   <= tmoNext;
      if (errSet) tmoErr <= 1'b1;
    end
  end

  always_comb begin
    stateNext  = RUN;
    tmoNext    = '0;
    errSet     = 1'b0;
    allowMem   = 1'b1;
    allowBr    = 1'b1;
    allowLu    = 1'b1;
    pcWe       = 1'b1;
    ifidEn     = 1'b1;
    idexEn     = 1'b1;
    exmemEn    = 1'b1;
    memwbEn    = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    memwbFlush = 1'b0;

    case (state)
      RUN: ;
      LU_STALL: allowLu = 1'b0;
      REDIRECT: begin
        allowBr = 1'b0;
        allowLu = 1'b0;
      end
      MEM_WAIT: begin
        // Timeout releases exactly like dmem_ready would, so memwait is masked this cycle.
        allowMem = ~tmoHit;
        errSet   = memWait & tmoHit;
      end
      default: ;
    endcase

    if (allowMem && memWait) begin
      pcWe       = 1'b0;
      ifidEn     = 1'b0;
      idexEn     = 1'b0;
      exmemEn    = 1'b0;
      memwbFlush = 1'b1;
      tmoNext    = (state == MEM_WAIT) ? tmo + TMO_W'(1) : TMO_W'(1);
      stateNext  = MEM_WAIT;
    end else if (allowBr && hz.exmem_br_taken) begin
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      stateNext  = REDIRECT;
    end else if (allowLu && luHaz) begin
      pcWe      = 1'b0;
      ifidEn    = 1'b0;
      idexFlush = 1'b1;
      stateNext = LU_STALL;
    end

    if (rst) begin
      pcWe       = 1'b0;
      ifidEn     = 1'b0;
      idexEn     = 1'b0;
      exmemEn    = 1'b0;
      memwbEn    = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      memwbFlush = 1'b1;
    end
  end

  assign hz.pc_we       = pcWe;
  assign hz.ifid_en     = ifidEn;
  assign hz.idex_en     = idexEn;
  assign hz.exmem_en    = exmemEn;
  assign hz.memwb_en    = memwbEn;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idex_flush  = idexFlush;
  assign hz.exmem_flush = exmemFlush;
  assign hz.memwb_flush = memwbFlush;
  assign hz.mem_tmo_err = tmoErr;

`ifdef PIPE_HZD_PERF_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [CNT_W-1:0] memwaitCnt;

  // The next state uniquely identifies which event was issued this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt   <= '0;
      flushCnt   <= '0;
      memwaitCnt <= '0;
    end else begin
      if (stateNext == LU_STALL && ~&stallCnt)   stallCnt   <= stallCnt + CNT_W'(1);
      if (stateNext == REDIRECT && ~&flushCnt)   flushCnt   <= flushCnt + CNT_W'(1);
      if (stateNext == MEM_WAIT && ~&memwaitCnt) memwaitCnt <= memwaitCnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt   = stallCnt;
  assign hz.flush_cnt   = flushCnt;
  assign hz.memwait_cnt = memwaitCnt;
`else
  assign hz.stall_cnt   = '0;
  assign hz.flush_cnt   = '0;
  assign hz.memwait_cnt = '0;
`endif

endmodule
